monitor_frame_rx: RTL and testbench
===================================

Name: monitor_frame_rx

Overview:
- Parametrised frame receiver for power-monitor telemetry: successor to the fixed 96-bit monitor receive controller.
- Reads UART bytes from the existing byte FIFO (non-show-ahead, q valid one cycle after rdreq) and hunts for a two-byte header.
- Assembles NUM_CH channels of CH_W bits, verifies an 8-bit additive checksum and publishes the words atomically.
- Adds inter-byte timeout recovery, error/frame statistics and link-health indication; sits between fifo_d1kw8_st and the monitor register bank.

Parameters:
NUM_CH, 6, number of channels per frame (1..16)
CH_W, 16, bits per channel, multiple of 8 (8..32)
HDR0, 8'hEB, first header byte
HDR1, 8'h90, second header byte
TIMEOUT_CYC, 6000, max sclk cycles between bytes inside a frame (>=16)
LINK_CYC, 60000000, sclk cycles without a good frame before link_ok drops

Ports:
sclk  input  1  system clock (60 MHz)
rst_n  input  1  asynchronous active-low reset
fifo_empty  input  1  byte FIFO empty flag
fifo_data  input  8  byte FIFO q, valid the cycle after fifo_rd_en
fifo_rd_en  output  1  byte FIFO read request
data_ov  output  NUM_CH*CH_W  last good frame payload; channel 0 in MSBs
data_update  output  1  one-cycle pulse when data_ov is updated
frame_cnt  output  16  good frames, saturating
chk_err_cnt  output  16  checksum failures, saturating
timeout_cnt  output  16  inter-byte timeouts, saturating
link_ok  output  1  high while a good frame arrived within LINK_CYC

Behaviour:
- Reset (async, rst_n low): all outputs 0, FSM to S_HDR0, shift register, checksum and timers cleared.
- Read handshake: fifo_rd_en=1 for one cycle when !fifo_empty and no read is pending. The byte is taken from fifo_data on the next cycle (byte_vld). There are never back-to-back reads, so max rate is 1 byte/2 cycles. fifo_rd_en is never asserted while fifo_empty=1.
- PAY_BYTES = NUM_CH*CH_W/8; the byte counter is wide enough for PAY_BYTES-1.
- FSM (advances only on byte_vld):
  - S_HDR0: byte==HDR0 -> S_HDR1; else stay.
  - S_HDR1: byte==HDR1 -> S_PAY, cnt=0, sum=0. Byte==HDR0 -> stay in S_HDR1. Else -> S_HDR0.
  - S_PAY: shift byte into payload register (first byte ends in MSB), sum+=byte mod 256, cnt++. When cnt==PAY_BYTES-1 -> S_CHK.
  - S_CHK: byte==sum -> data_ov<=payload, data_update=1 on the following cycle, frame_cnt++. Mismatch -> chk_err_cnt++, data_ov unchanged. Either way -> S_HDR0.
- Checksum covers payload bytes only, not the header.
- data_ov changes only on a good frame and all channels update in the same cycle; a partial frame never leaks.
- Timeout: idle counter clears on every byte_vld and counts while the FSM is not in S_HDR0. Reaching TIMEOUT_CYC -> S_HDR0, timeout_cnt++, counter cleared. Never counts in S_HDR0.
- Simultaneous timeout and byte_vld: the byte wins and no timeout is recorded.
- Counters saturate at 16'hFFFF without wrap.
- link_ok: set with data_update. A 32-bit counter clears on each good frame; link_ok drops when it reaches LINK_CYC-1. Counter holds at terminal value.
- Latency: checksum byte captured at cycle T -> data_ov/data_update at T+1.

Decomposition:
- Shared package monitor_pkg: header constants, state encoding (S_HDR0/S_HDR1/S_PAY/S_CHK), counter width 16, sat-increment function.
- One natural sub-module: monitor_sat_cnt (parametrised width, inc/clear, saturating), instanced three times.
- Top-level wrapper replaces monitor_rx_ctrl with monitor_frame_rx, same uart_top and FIFO.

Test Plan:
- Good frame with defaults: EB 90 01 02 ... 0C, checksum 8'h4E -> data_ov=96'h0102_0304_0506_0708_090A_0B0C, one data_update pulse, frame_cnt=1, link_ok=1.
- Same frame with checksum 8'h4F -> data_ov stays 0, chk_err_cnt=1, frame_cnt=0, no data_update.
- Header resync: EB EB 90 + valid payload/checksum -> frame accepted. Stream 90 EB 00 EB 90 + valid frame -> exactly one frame accepted.
- Timeout: EB 90 01 02, then 6000 idle cycles -> timeout_cnt=1, FSM in S_HDR0. A following complete good frame is accepted and data_ov reflects only the new frame.
- Boundary and reset:
  - fifo_empty held high -> fifo_rd_en never asserted.
  - rst_n pulsed low mid-payload -> all outputs 0 immediately; a subsequent good frame is accepted.
  - LINK_CYC=1000 override: link_ok falls 1000 cycles after the last good frame.
- Parameter sweep NUM_CH=1/CH_W=8 and NUM_CH=4/CH_W=32: random frames vs. reference model. Counters forced near 16'hFFFE saturate at FFFF.

Source files
------------

// File: rtl/monitor_pkg.sv
// Shared definitions for the monitor telemetry receive path: header defaults,
// receiver state encoding, statistics counter width and a saturating increment.
package monitor_pkg;

  localparam int         CNT_W    = 16;
  localparam logic [7:0] HDR0_DEF = 8'hEB;
  localparam logic [7:0] HDR1_DEF = 8'h90;

  typedef enum logic [1:0] {
    S_HDR0 = 2'd0,
    S_HDR1 = 2'd1,
    S_PAY  = 2'd2,
    S_CHK  = 2'd3
  } rx_state_e;

  // Increments v but never beyond lim; used for statistics and the link timer.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v >= lim) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/monitor_sat_cnt.sv
// Saturating event counter (up to 32 bits wide) with a synchronous clear.
module monitor_sat_cnt
  import monitor_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [31:0] CNT_MAX = (WIDTH >= 32) ? 32'hFFFF_FFFF
                                                  : 32'((64'd1 << WIDTH) - 64'd1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = WIDTH'(sat_inc(32'(cnt_q), CNT_MAX));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/monitor_frame_rx.sv
// Telemetry frame receiver: hunts a two-byte header in the UART byte FIFO, assembles
// NUM_CH x CH_W channels, checks an additive checksum and publishes good frames atomically.
module monitor_frame_rx
  import monitor_pkg::*;
#(
  parameter int         NUM_CH      = 6,
  parameter int         CH_W        = 16,
  parameter logic [7:0] HDR0        = HDR0_DEF,
  parameter logic [7:0] HDR1        = HDR1_DEF,
  parameter int         TIMEOUT_CYC = 6000,
  parameter int         LINK_CYC    = 60000000
) (
  input  logic                     sclk,
  input  logic                     rst_n,
  input  logic                     fifo_empty,
  input  logic [7:0]               fifo_data,
  output logic                     fifo_rd_en,
  output logic [NUM_CH*CH_W-1:0]   data_ov,
  output logic                     data_update,
  output logic [CNT_W-1:0]         frame_cnt,
  output logic [CNT_W-1:0]         chk_err_cnt,
  output logic [CNT_W-1:0]         timeout_cnt,
  output logic                     link_ok,
  output logic [1:0]               dbg_state_o
);

  localparam int PAY_W     = NUM_CH * CH_W;
  localparam int PAY_BYTES = PAY_W / 8;
  localparam int BC_W      = (PAY_BYTES > 1) ? $clog2(PAY_BYTES) : 1;
  localparam int TO_W      = $clog2(TIMEOUT_CYC);

  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(PAY_BYTES - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [31:0]     LINK_LAST = 32'(LINK_CYC - 1);

  // FIFO handshake: fifo_rd_en is a one-cycle request, and fifo_data is consumed
  // in the following cycle (byte_vld_q). A new request is only issued once the
  // previous one has been answered, so bytes arrive at most every other cycle.
  logic              rd_en_q;
  logic              rd_en_d;
  logic              byte_vld_q;

  rx_state_e         state_q;
  logic [BC_W-1:0]   bcnt_q;
  logic [7:0]        sum_q;
  logic [PAY_W-1:0]  pay_q;
  logic [PAY_W-1:0]  data_q;
  logic              upd_q;
  logic [TO_W-1:0]   to_q;
  logic [31:0]       link_cnt_q;
  logic [31:0]       link_cnt_d;
  logic              link_ok_q;

  logic              in_chk;
  logic              good_frame;
  logic              bad_frame;
  logic              timeout_hit;

  assign rd_en_d     = !fifo_empty && !rd_en_q;
  assign in_chk      = byte_vld_q && (state_q == S_CHK);
  assign good_frame  = in_chk && (fifo_data == sum_q);
  assign bad_frame   = in_chk && (fifo_data != sum_q);
  // An arriving byte always pre-empts an expiring idle timer.
  assign timeout_hit = !byte_vld_q && (state_q != S_HDR0) && (to_q == TO_LAST);
  assign link_cnt_d  = good_frame ? 32'd0 : sat_inc(link_cnt_q, LINK_LAST);

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q    <= 1'b0;
      byte_vld_q <= 1'b0;
      state_q    <= S_HDR0;
      bcnt_q     <= '0;
      sum_q      <= '0;
      pay_q      <= '0;
      data_q     <= '0;
      upd_q      <= 1'b0;
      to_q       <= '0;
      link_cnt_q <= '0;
      link_ok_q  <= 1'b0;
    end else begin
      rd_en_q    <= rd_en_d;
      byte_vld_q <= rd_en_q;
      upd_q      <= good_frame;
      link_cnt_q <= link_cnt_d;

      if (good_frame) begin
        link_ok_q <= 1'b1;
        data_q    <= pay_q;
      end else if (link_cnt_d == LINK_LAST) begin
        link_ok_q <= 1'b0;
      end

      if (byte_vld_q || (state_q == S_HDR0) || timeout_hit) begin
        to_q <= '0;
      end else begin
        to_q <= to_q + 1'b1;
      end

      if (timeout_hit) begin
        state_q <= S_HDR0;
      end else if (byte_vld_q) begin
        unique case (state_q)
          S_HDR0: begin
            if (fifo_data == HDR0) state_q <= S_HDR1;
          end
          S_HDR1: begin
            // A repeated first header byte keeps us aligned on the second one.
            if (fifo_data == HDR1) begin
              state_q <= S_PAY;
              bcnt_q  <= '0;
              sum_q   <= '0;
            end else if (fifo_data != HDR0) begin
              state_q <= S_HDR0;
            end
          end
          S_PAY: begin
            pay_q  <= PAY_W'({pay_q, fifo_data});
            sum_q  <= sum_q + fifo_data;
            bcnt_q <= bcnt_q + 1'b1;
            if (bcnt_q == LAST_BYTE) state_q <= S_CHK;
          end
          S_CHK: begin
            state_q <= S_HDR0;
          end
          default: begin
            state_q <= S_HDR0;
          end
        endcase
      end
    end
  end

  monitor_sat_cnt #(.WIDTH(CNT_W)) u_frame_cnt (
    .clk_i  (sclk),
    .rst_ni (rst_n),
    .clr_i  (1'b0),
    .inc_i  (good_frame),
    .cnt_o  (frame_cnt)
  );

  monitor_sat_cnt #(.WIDTH(CNT_W)) u_chk_err_cnt (
    .clk_i  (sclk),
    .rst_ni (rst_n),
    .clr_i  (1'b0),
    .inc_i  (bad_frame),
    .cnt_o  (chk_err_cnt)
  );

  monitor_sat_cnt #(.WIDTH(CNT_W)) u_timeout_cnt (
    .clk_i  (sclk),
    .rst_ni (rst_n),
    .clr_i  (1'b0),
    .inc_i  (timeout_hit),
    .cnt_o  (timeout_cnt)
  );

  assign fifo_rd_en  = rd_en_q;
  assign data_ov     = data_q;
  assign data_update = upd_q;
  assign link_ok     = link_ok_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_monitor_frame_rx.sv
// Bench for monitor_frame_rx: default, 1x8 and 4x32 instances fed from queue FIFO
// models, plus a narrow monitor_sat_cnt for the saturation boundary.
module tb_monitor_frame_rx;

  logic sclk  = 1'b0;
  logic rst_n = 1'b1;
  always #5 sclk = ~sclk;

  logic        fe [3] = '{1'b1, 1'b1, 1'b1};
  logic [7:0]  fd [3] = '{8'd0, 8'd0, 8'd0};
  logic        rd [3];
  logic        up [3];
  logic        lk [3];
  logic [15:0] fc [3];
  logic [15:0] ec [3];
  logic [15:0] tc [3];
  logic [1:0]  st [3];
  logic [95:0]  ov0;
  logic [7:0]   ov1;
  logic [127:0] ov2;

  logic       sat_inc_s = 1'b0;
  logic       sat_clr_s = 1'b0;
  logic [3:0] sat_cnt;

  logic [7:0]   fq    [3][$];
  logic [127:0] exp_q [3][$];
  logic [127:0] got_q [3][$];
  int exp_fc [3];
  int exp_ec [3];
  int exp_to [3];

  int checks = 0;
  int errors = 0;
  int rd_bad = 0;
  logic [31:0] cyc = 0;
  logic [31:0] last_upd1 = 0;

  monitor_frame_rx u_d0 (
    .sclk(sclk), .rst_n(rst_n), .fifo_empty(fe[0]), .fifo_data(fd[0]), .fifo_rd_en(rd[0]),
    .data_ov(ov0), .data_update(up[0]), .frame_cnt(fc[0]), .chk_err_cnt(ec[0]),
    .timeout_cnt(tc[0]), .link_ok(lk[0]), .dbg_state_o(st[0])
  );

  monitor_frame_rx #(.NUM_CH(1), .CH_W(8), .LINK_CYC(1000)) u_d1 (
    .sclk(sclk), .rst_n(rst_n), .fifo_empty(fe[1]), .fifo_data(fd[1]), .fifo_rd_en(rd[1]),
    .data_ov(ov1), .data_update(up[1]), .frame_cnt(fc[1]), .chk_err_cnt(ec[1]),
    .timeout_cnt(tc[1]), .link_ok(lk[1]), .dbg_state_o(st[1])
  );

  monitor_frame_rx #(.NUM_CH(4), .CH_W(32)) u_d2 (
    .sclk(sclk), .rst_n(rst_n), .fifo_empty(fe[2]), .fifo_data(fd[2]), .fifo_rd_en(rd[2]),
    .data_ov(ov2), .data_update(up[2]), .frame_cnt(fc[2]), .chk_err_cnt(ec[2]),
    .timeout_cnt(tc[2]), .link_ok(lk[2]), .dbg_state_o(st[2])
  );

  monitor_sat_cnt #(.WIDTH(4)) u_sat (
    .clk_i(sclk), .rst_ni(rst_n), .clr_i(sat_clr_s), .inc_i(sat_inc_s), .cnt_o(sat_cnt)
  );

  // Non-show-ahead FIFO models: q updates on the edge after a read request.
  always @(posedge sclk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (rd[i] && fq[i].size() != 0) fd[i] <= fq[i].pop_front();
      fe[i] <= (fq[i].size() == 0);
    end
  end

  always @(negedge sclk) begin
    if (up[0]) got_q[0].push_back(128'(ov0));
    if (up[1]) begin
      got_q[1].push_back(128'(ov1));
      last_upd1 = cyc;
    end
    if (up[2]) got_q[2].push_back(128'(ov2));
    for (int i = 0; i < 3; i++) begin
      if (rd[i] && fe[i]) rd_bad = rd_bad + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sclk);
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int pay_bytes(input int i);
    return (i == 0) ? 12 : (i == 1) ? 1 : 16;
  endfunction

  // Reference model: a frame is good exactly when its trailer equals the byte sum mod 256.
  task automatic send_frame(input int i, input logic [127:0] val, input logic [7:0] delta);
    int n;
    logic [7:0] b;
    logic [7:0] s;
    logic [127:0] pv;
    n = pay_bytes(i);
    s = 8'd0;
    pv = '0;
    fq[i].push_back(8'hEB);
    fq[i].push_back(8'h90);
    for (int k = 0; k < n; k++) begin
      b = val[8*(n-1-k) +: 8];
      s = s + b;
      pv = (pv << 8) | 128'(b);
      fq[i].push_back(b);
    end
    fq[i].push_back(s + delta);
    if (delta == 8'd0) begin
      exp_q[i].push_back(pv);
      exp_fc[i]++;
    end else begin
      exp_ec[i]++;
    end
  endtask

  task automatic wait_drain(input int i);
    int n;
    n = 0;
    while (fq[i].size() != 0 && n < 3000) begin
      tick(1);
      n++;
    end
    tick(8);
    chk($sformatf("drain%0d", i), 128'(fq[i].size()), 128'd0);
  endtask

  task automatic check_sb(input int i);
    logic [127:0] e;
    logic [127:0] g;
    chk($sformatf("upd_count%0d", i), 128'(got_q[i].size()), 128'(exp_q[i].size()));
    while (exp_q[i].size() != 0 && got_q[i].size() != 0) begin
      e = exp_q[i].pop_front();
      g = got_q[i].pop_front();
      chk($sformatf("payload%0d", i), g, e);
    end
    exp_q[i].delete();
    got_q[i].delete();
  endtask

  task automatic check_cnt(input int i);
    chk($sformatf("frame_cnt%0d", i), 128'(fc[i]), 128'(exp_fc[i]));
    chk($sformatf("chk_err_cnt%0d", i), 128'(ec[i]), 128'(exp_ec[i]));
    chk($sformatf("timeout_cnt%0d", i), 128'(tc[i]), 128'(exp_to[i]));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      fq[i].delete();
      exp_q[i].delete();
      got_q[i].delete();
      exp_fc[i] = 0;
      exp_ec[i] = 0;
      exp_to[i] = 0;
    end
  endtask

  function automatic logic [7:0] garbage();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    return (b == 8'hEB) ? 8'h00 : b;
  endfunction

  initial begin
    logic [127:0] v;
    logic [95:0]  hold;
    int n;

    model_reset();
    tick(1);
    rst_n = 1'b0;
    tick(5);
    chk("rst_data_ov", 128'(ov0), 128'd0);
    chk("rst_update", 128'(up[0]), 128'd0);
    chk("rst_link", 128'(lk[0]), 128'd0);
    chk("rst_rd_en", 128'(rd[0]), 128'd0);
    chk("rst_state", 128'(st[0]), 128'd0);
    check_cnt(0);
    rst_n = 1'b1;

    // Empty FIFO: no read requests, no state change.
    tick(50);
    chk("empty_no_read", 128'(rd_bad), 128'd0);
    chk("empty_state", 128'(st[0]), 128'd0);

    // Reference frame 01..0C, checksum 4E.
    send_frame(0, 128'h0102_0304_0506_0708_090A_0B0C, 8'd0);
    wait_drain(0);
    chk("ref_data_ov", 128'(ov0), 128'h0102_0304_0506_0708_090A_0B0C);
    chk("ref_link", 128'(lk[0]), 128'd1);
    check_sb(0);
    check_cnt(0);
    hold = ov0;

    // Corrupted checksum: payload must not leak.
    send_frame(0, {$urandom, $urandom, $urandom, $urandom}, 8'd1);
    wait_drain(0);
    chk("bad_hold_ov", 128'(ov0), 128'(hold));
    check_sb(0);
    check_cnt(0);

    // Resync on repeated EB, then on 90 EB 00 noise.
    fq[0].push_back(8'hEB);
    send_frame(0, {$urandom, $urandom, $urandom, $urandom}, 8'd0);
    fq[0].push_back(8'h90);
    fq[0].push_back(8'hEB);
    fq[0].push_back(8'h00);
    send_frame(0, {$urandom, $urandom, $urandom, $urandom}, 8'd0);
    wait_drain(0);
    check_sb(0);
    check_cnt(0);
    hold = ov0;

    // Inter-byte timeout inside a payload.
    fq[0].push_back(8'hEB);
    fq[0].push_back(8'h90);
    fq[0].push_back(8'h01);
    fq[0].push_back(8'h02);
    wait_drain(0);
    chk("to_state_pay", 128'(st[0]), 128'd2);
    tick(5780);
    chk("to_not_yet", 128'(tc[0]), 128'd0);
    tick(300);
    exp_to[0] = 1;
    chk("to_state_hdr0", 128'(st[0]), 128'd0);
    chk("to_hold_ov", 128'(ov0), 128'(hold));
    send_frame(0, {$urandom, $urandom, $urandom, $urandom}, 8'd0);
    wait_drain(0);
    check_sb(0);
    check_cnt(0);

    // Asynchronous reset in the middle of a payload.
    send_frame(0, {$urandom, $urandom, $urandom, $urandom}, 8'd0);
    tick(14);
    chk("mid_state_pay", 128'(st[0]), 128'd2);
    rst_n = 1'b0;
    #1;
    chk("arst_data_ov", 128'(ov0), 128'd0);
    chk("arst_link", 128'(lk[0]), 128'd0);
    chk("arst_rd_en", 128'(rd[0]), 128'd0);
    chk("arst_state", 128'(st[0]), 128'd0);
    model_reset();
    check_cnt(0);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    send_frame(0, {$urandom, $urandom, $urandom, $urandom}, 8'd0);
    wait_drain(0);
    check_sb(0);
    check_cnt(0);

    // Random frames on the 1x8 and 4x32 instances.
    for (int f = 0; f < 24; f++) begin
      for (int i = 1; i < 3; i++) begin
        n = $urandom_range(0, 3);
        repeat (n) fq[i].push_back(garbage());
        send_frame(i, {$urandom, $urandom, $urandom, $urandom},
                   ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0);
      end
      if ($urandom_range(0, 1) == 1) tick($urandom_range(1, 40));
    end
    wait_drain(1);
    wait_drain(2);
    check_sb(1);
    check_sb(2);
    check_cnt(1);
    check_cnt(2);

    // Link health on the instance with a 1000-cycle window.
    v = 128'($urandom_range(0, 255));
    send_frame(1, v, 8'd0);
    wait_drain(1);
    check_sb(1);
    chk("link1_up", 128'(lk[1]), 128'd1);
    while (cyc < last_upd1 + 990) tick(1);
    chk("link1_before", 128'(lk[1]), 128'd1);
    while (cyc < last_upd1 + 1010) tick(1);
    chk("link1_dropped", 128'(lk[1]), 128'd0);
    chk("link0_held", 128'(lk[0]), 128'd1);

    // Saturation of the counter primitive.
    sat_clr_s = 1'b1;
    tick(1);
    sat_clr_s = 1'b0;
    chk("sat_clear", 128'(sat_cnt), 128'd0);
    sat_inc_s = 1'b1;
    tick(14);
    chk("sat_near_max", 128'(sat_cnt), 128'd14);
    tick(1);
    chk("sat_max", 128'(sat_cnt), 128'd15);
    tick(3);
    chk("sat_hold", 128'(sat_cnt), 128'd15);
    sat_inc_s = 1'b0;
    sat_clr_s = 1'b1;
    tick(1);
    sat_clr_s = 1'b0;
    chk("sat_clr_after", 128'(sat_cnt), 128'd0);

    chk("rd_while_empty", 128'(rd_bad), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
